// File: rtl/seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl
//
// Front-end controller and arbiter for the 8-digit 7-segment display device.
//   * Free-running digit scan index (scan) and blink level (blink).
//   * Round-robin arbitration between two requesters (0: game/score,
//     1: debug). Arbitration happens only on a frame boundary (the last
//     prescaler count of scan digit 3), so the display never changes
//     mid-frame.
//   * After each latch, sequences the serial shift-out: a one-cycle
//     parallel-load strobe, then exactly 64 io_clk pulses.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   req0/1                 update request, held by the requester until ack
//   data0/1  [31:0]        hex data, 8 nibbles
//   point0/1 [7:0]         decimal points
//   les0/1   [7:0]         per-digit blink enables
//   ack0/1                 one-cycle grant/latch acknowledge
//   scan     [1:0]         digit scan index
//   blink                  blink level
//   data_o/point_o/les_o   latched display contents
//   owner                  requester whose data is currently latched
//   io_load                one-cycle parallel-load strobe to the shifter
//   io_clk                 shift clock to the shifter (idles low)
//   busy                   high from the latch cycle to the end of shifting
// ---------------------------------------------------------------------------
module seg7_display_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int SHIFT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [7:0]  point0,
  input  logic [7:0]  les0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [7:0]  point1,
  input  logic [7:0]  les1,
  output logic        ack1,
  output logic [1:0]  scan,
  output logic        blink,
  output logic [31:0] data_o,
  output logic [7:0]  point_o,
  output logic [7:0]  les_o,
  output logic        owner,
  output logic        io_load,
  output logic        io_clk,
  output logic        busy
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SHIFT_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SHIFT_LO = 2'd2,
    ST_SHIFT_HI = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Scan and blink timebases (run in every FSM state)
  // -------------------------------------------------------------------------
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         scan_q, scan_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               scan_term;
  logic               blink_term;
  logic               frame_tick;

  assign scan_term  = (scan_cnt_q == SCAN_LAST);
  assign blink_term = (blink_cnt_q == BLINK_LAST);
  // Last dwell cycle of the last digit: the frame boundary.
  assign frame_tick = scan_term && (scan_q == 2'd3);

  always_comb begin
    scan_cnt_d  = scan_term ? '0 : scan_cnt_q + 1'b1;
    scan_d      = scan_term ? scan_q + 2'd1 : scan_q;  // wraps 3 -> 0
    blink_cnt_d = blink_term ? '0 : blink_cnt_q + 1'b1;
    blink_d     = blink_term ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      scan_q      <= 2'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_q      <= scan_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin grant selection
  // -------------------------------------------------------------------------
  logic last_grant_q;
  logic grant_sel;  // 0 = requester 0, 1 = requester 1

  // A tie goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    if (req0 && req1) grant_sel = ~last_grant_q;
    else              grant_sel = req1;
  end

  // -------------------------------------------------------------------------
  // Latch / shift-out sequencer with registered outputs
  // -------------------------------------------------------------------------
  state_t             state_q;
  logic [SHIFT_W-1:0] phase_cnt_q;
  logic [5:0]         bit_cnt_q;
  logic               ack0_q, ack1_q;
  logic [31:0]        data_q;
  logic [7:0]         point_q, les_q;
  logic               owner_q;
  logic               io_load_q, io_clk_q, busy_q;
  logic               phase_last;

  assign phase_last = (phase_cnt_q == SHIFT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_cnt_q  <= '0;
      bit_cnt_q    <= 6'd0;
      last_grant_q <= 1'b1;  // makes requester 0 win the first tie
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      data_q       <= 32'd0;
      point_q      <= 8'd0;
      les_q        <= 8'd0;
      owner_q      <= 1'b0;
      io_load_q    <= 1'b0;
      io_clk_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      io_load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Frame ticks during busy are simply never seen here, so the
          // first tick after returning to IDLE is the next arbitration slot.
          if (frame_tick && (req0 || req1)) begin
            state_q      <= ST_LOAD;
            ack0_q       <= ~grant_sel;
            ack1_q       <= grant_sel;
            data_q       <= grant_sel ? data1  : data0;
            point_q      <= grant_sel ? point1 : point0;
            les_q        <= grant_sel ? les1   : les0;
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            io_load_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q     <= ST_SHIFT_LO;
          phase_cnt_q <= '0;
          bit_cnt_q   <= 6'd0;
          io_clk_q    <= 1'b0;
        end
        ST_SHIFT_LO: begin
          if (phase_last) begin
            state_q     <= ST_SHIFT_HI;
            phase_cnt_q <= '0;
            io_clk_q    <= 1'b1;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_last) begin
            phase_cnt_q <= '0;
            io_clk_q    <= 1'b0;  // every pulse completes; io_clk ends low
            if (bit_cnt_q == 6'd63) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              state_q   <= ST_SHIFT_LO;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign scan    = scan_q;
  assign blink   = blink_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign data_o  = data_q;
  assign point_o = point_q;
  assign les_o   = les_q;
  assign owner   = owner_q;
  assign io_load = io_load_q;
  assign io_clk  = io_clk_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Directed phases plus randomized request traffic. A timeline reference
// model (cycles since reset, frame index, offset from the LOAD cycle) runs on
// the falling edge and pushes one expected output snapshot per cycle, plus
// one expected transaction per grant. A separate monitor pops and compares
// one snapshot every cycle and one transaction on every ack.
// ---------------------------------------------------------------------------
module tb_seg7_display_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int SHIFT_DIV = 2;
  localparam int FRAME     = 4 * SCAN_DIV;
  localparam int SHIFT_LEN = 128 * SHIFT_DIV;  // shift cycles after LOAD

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = 32'd0, data1 = 32'd0;
  logic [7:0]  point0 = 8'd0, point1 = 8'd0, les0 = 8'd0, les1 = 8'd0;
  logic        ack0, ack1;
  logic [1:0]  scan;
  logic        blink;
  logic [31:0] data_o;
  logic [7:0]  point_o, les_o;
  logic        owner, io_load, io_clk, busy;

  seg7_display_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV),
    .SHIFT_DIV(SHIFT_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .point0(point0), .les0(les0), .ack0(ack0),
    .req1(req1), .data1(data1), .point1(point1), .les1(les1), .ack1(ack1),
    .scan(scan), .blink(blink), .data_o(data_o), .point_o(point_o),
    .les_o(les_o), .owner(owner), .io_load(io_load), .io_clk(io_clk),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  scan;
    logic        blink, busy, io_load, io_clk, ack0, ack1, owner;
    logic [31:0] data;
    logic [7:0]  point, les;
  } exp_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic [7:0]  point, les;
    int          cyc;
  } txn_t;

  exp_t cyc_q[$];
  txn_t txn_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          gcyc     = 0;   // global cycle index
  int          m_cyc    = 0;   // cycles since reset release
  int          load_cyc = -1;  // global index of the latest LOAD cycle
  logic        m_last   = 1'b1;
  logic        m_owner  = 1'b0;
  logic [31:0] m_data   = 32'd0;
  logic [7:0]  m_point  = 8'd0, m_les = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got %h, expected %h", name, gcyc, act, exp_v);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: decides from the inputs of this cycle what the DUT must
  // show next cycle.
  // -------------------------------------------------------------------------
  initial begin : model
    exp_t e;
    txn_t t;
    int   j;
    logic g;
    logic busy_now;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cyc    = 0;
        load_cyc = -1;
        m_last   = 1'b1;
        m_owner  = 1'b0;
        m_data   = 32'd0;
        m_point  = 8'd0;
        m_les    = 8'd0;
      end else begin
        busy_now = (load_cyc >= 0) && (gcyc - load_cyc <= SHIFT_LEN);
        if (!busy_now && (m_cyc % FRAME == FRAME - 1) && (req0 || req1)) begin
          g        = (req0 && req1) ? ~m_last : req1;
          m_last   = g;
          m_owner  = g;
          m_data   = g ? data1  : data0;
          m_point  = g ? point1 : point0;
          m_les    = g ? les1   : les0;
          load_cyc = gcyc + 1;
          t.owner = g; t.data = m_data; t.point = m_point; t.les = m_les;
          t.cyc   = load_cyc;
          txn_q.push_back(t);
        end
        m_cyc++;
      end
      gcyc++;
      j         = gcyc - load_cyc;
      e.scan    = 2'((m_cyc / SCAN_DIV) % 4);
      e.blink   = ((m_cyc / BLINK_DIV) % 2) == 0;
      e.busy    = (load_cyc >= 0) && (j >= 0) && (j <= SHIFT_LEN);
      e.io_load = (load_cyc >= 0) && (j == 0);
      e.io_clk  = e.busy && (j >= 1) && (((j - 1) / SHIFT_DIV) % 2 == 1);
      e.ack0    = e.io_load && (m_owner == 1'b0);
      e.ack1    = e.io_load && (m_owner == 1'b1);
      e.owner   = m_owner;
      e.data    = m_data;
      e.point   = m_point;
      e.les     = m_les;
      cyc_q.push_back(e);
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: compares every cycle, and pops a transaction on every ack.
  // -------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("scan",    scan,    e.scan);
        chk("blink",   blink,   e.blink);
        chk("busy",    busy,    e.busy);
        chk("io_load", io_load, e.io_load);
        chk("io_clk",  io_clk,  e.io_clk);
        chk("ack0",    ack0,    e.ack0);
        chk("ack1",    ack1,    e.ack1);
        chk("owner",   owner,   e.owner);
        chk("data_o",  data_o,  e.data);
        chk("point_o", point_o, e.point);
        chk("les_o",   les_o,   e.les);
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
          if (txn_q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
          end else begin
            t = txn_q.pop_front();
            chk("txn_ack_owner", {31'd0, ack1}, {31'd0, t.owner});
            chk("txn_data",      data_o,  t.data);
            chk("txn_point",     point_o, t.point);
            chk("txn_les",       les_o,   t.les);
            $display("txn: ack%0d data=%h point=%h les=%h load_cycle=%0d",
                     ack1 ? 1 : 0, data_o, point_o, les_o, t.cyc);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ack(input int r, input int limit);
    int k;
    k = 0;
    while (((r == 0) ? ack0 : ack1) !== 1'b1 && k < limit) begin
      step(1);
      k++;
    end
    chk((r == 0) ? "wait_ack0_timeout" : "wait_ack1_timeout",
        {31'd0, (k >= limit)}, 32'd0);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < limit) begin
      step(1);
      k++;
    end
    chk("wait_idle_timeout", {31'd0, (k >= limit)}, 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : stim
    int edges;
    logic prev_clk;

    // 1. reset, then free-running scan/blink with no requests
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      data0 = $urandom; data1 = $urandom;
      point0 = 8'($urandom); les1 = 8'($urandom);
      step(1);
    end

    // 2. single request from requester 0
    data0 = 32'h12345678; point0 = 8'h01; les0 = 8'h00;
    req0  = 1'b1;
    wait_ack(0, 40);
    req0 = 1'b0;
    wait_idle(SHIFT_LEN + 10);

    // 4. requester 1 arrives mid-shift of a requester-0 update
    step(5);
    req0 = 1'b1;
    wait_ack(0, 40);
    req0 = 1'b0;
    step(20);
    data1 = $urandom; point1 = 8'($urandom); les1 = 8'($urandom);
    req1 = 1'b1;
    wait_ack(1, SHIFT_LEN + 40);
    req1 = 1'b0;
    wait_idle(SHIFT_LEN + 10);

    // 5. reset on the 20th io_clk rising edge with requester 1 waiting
    step(3);
    req0 = 1'b1;
    wait_ack(0, 40);
    req0 = 1'b0;
    data1 = 32'hCAFEF00D; point1 = 8'h80; les1 = 8'h0F;
    req1 = 1'b1;
    edges = 0;
    prev_clk = io_clk;
    for (int k = 0; k < SHIFT_LEN && edges < 20; k++) begin
      step(1);
      if (io_clk === 1'b1 && prev_clk === 1'b0) edges++;
      prev_clk = io_clk;
    end
    chk("io_clk_edges_before_rst", edges, 20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_ack(1, 40);
    req1 = 1'b0;
    wait_idle(SHIFT_LEN + 10);

    // 3. both requesters held: grants must alternate starting with 0
    data0 = 32'h12345678; point0 = 8'h01; les0 = 8'h00;
    data1 = 32'hDEADBEEF; point1 = 8'h10; les1 = 8'hF0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int k;
      k = 0;
      while (ack0 !== 1'b1 && ack1 !== 1'b1 && k < SHIFT_LEN + 40) begin
        step(1);
        k++;
      end
      chk("tie_timeout", {31'd0, (k >= SHIFT_LEN + 40)}, 32'd0);
      chk("tie_order", {31'd0, owner}, n % 2);
      step(1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle(SHIFT_LEN + 10);
    step(20);  // let any grant decided in the drop cycle finish

    // 6. short req0 pulse that misses every frame tick
    wait_idle(SHIFT_LEN + 10);
    for (int k = 0; k < 2 * FRAME && (m_cyc % FRAME) != 2; k++) step(1);
    req0 = 1'b1;
    step(2);
    req0 = 1'b0;
    step(40);

    // 7. randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 99) < 4) begin
        req0 = 1'b1; data0 = $urandom; point0 = 8'($urandom); les0 = 8'($urandom);
      end else if (req0 && $urandom_range(0, 299) == 0) req0 = 1'b0;
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 99) < 4) begin
        req1 = 1'b1; data1 = $urandom; point1 = 8'($urandom); les1 = 8'($urandom);
      end else if (req1 && $urandom_range(0, 299) == 0) req1 = 1'b0;
      rst = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    step(2);
    wait_idle(SHIFT_LEN + 10);
    step(10);
    chk("pending_txn", txn_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
